// File: rtl/alu32.sv
// 32-bit registered ALU for the execute stage: eight operations selected by
// ALUopcode, with result and zero/sign flags captured on the rising clock edge.
module alu32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALUopcode,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic [31:0] result,
    output logic        zero,
    output logic        sign
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_SLTU = 3'd4,
        OP_SLT  = 3'd5,
        OP_XOR  = 3'd6,
        OP_NOR  = 3'd7
    } op_e;

    // Differing signs decide the answer directly; with equal signs the low
    // bits compare correctly as unsigned, so no subtraction overflow arises.
    function automatic logic lt_signed(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        if (a[DATA_W-1] != b[DATA_W-1])
            return a[DATA_W-1];
        return (a[DATA_W-2:0] < b[DATA_W-2:0]);
    endfunction

    function automatic logic lt_unsigned(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        return (a < b);
    endfunction

    logic [DATA_W-1:0] result_d, result_q;
    logic              zero_d,   zero_q;
    logic              sign_d,   sign_q;

    always_comb begin
        result_d = '0;
        case (op_e'(ALUopcode))
            OP_ADD:  result_d = rega + regb;
            OP_SUB:  result_d = rega - regb;
            OP_AND:  result_d = rega & regb;
            OP_OR:   result_d = rega | regb;
            OP_SLTU: result_d = {{(DATA_W-1){1'b0}}, lt_unsigned(rega, regb)};
            OP_SLT:  result_d = {{(DATA_W-1){1'b0}}, lt_signed(rega, regb)};
            OP_XOR:  result_d = rega ^ regb;
            OP_NOR:  result_d = ~(rega | regb);
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
        sign_d = result_d[DATA_W-1];
    end

    // Execute-stage output register
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            sign_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign sign   = sign_q;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32: reset, each opcode group, signed/unsigned
// compare corners, output hold between edges and back-to-back throughput.
module tb_alu32;

    logic        clk;
    logic        rst;
    logic [2:0]  ALUopcode;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] result;
    logic        zero;
    logic        sign;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        s;
    } vec_t;

    alu32 dut (
        .clk(clk),
        .rst(rst),
        .ALUopcode(ALUopcode),
        .rega(rega),
        .regb(regb),
        .result(result),
        .zero(zero),
        .sign(sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    // Present inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst = r;
        ALUopcode = op;
        rega = a;
        regb = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t v[]);
        for (int i = 0; i < v.size(); i++) begin
            apply(1'b0, v[i].op, v[i].a, v[i].b);
            n_vec++;
            if ({result, zero, sign} !== {v[i].r, v[i].z, v[i].s}) begin
                n_bad++;
                $display("FAIL %s[%0d] op=%0d a=%h b=%h: got r=%h z=%b s=%b, want r=%h z=%b s=%b",
                         name, i, v[i].op, v[i].a, v[i].b, result, zero, sign,
                         v[i].r, v[i].z, v[i].s);
            end
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (a < b) ? 32'd1 : 32'd0;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic test_reset();
        apply(1'b1, 3'd0, 32'd7, 32'd9);
        n_vec++;
        if ({result, zero, sign} !== {32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold: got r=%h z=%b s=%b, want r=00000000 z=1 s=0", result, zero, sign);
        end
        apply(1'b0, 3'd0, 32'd7, 32'd9);
        n_vec++;
        if ({result, zero, sign} !== {32'd16, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got r=%h z=%b s=%b, want r=00000010 z=0 s=0", result, zero, sign);
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b0, 3'd1, 32'd1, 32'd2);
        apply(1'b1, 3'd7, 32'd0, 32'd0);
        n_vec++;
        if ({result, zero, sign} !== {32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_midstream: got r=%h z=%b s=%b, want r=00000000 z=1 s=0", result, zero, sign);
        end
        apply(1'b0, 3'd0, 32'd3, 32'd4);
        n_vec++;
        if ({result, zero, sign} !== {32'd7, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_midstream_release: got r=%h z=%b s=%b, want r=00000007 z=0 s=0", result, zero, sign);
        end
    endtask

    task automatic test_addsub();
        vec_t v[] = '{
            '{3'd0, 32'd1,        32'd1, 32'd2,        1'b0, 1'b0},
            '{3'd1, 32'd2,        32'd1, 32'd1,        1'b0, 1'b0},
            '{3'd1, 32'd1,        32'd2, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{3'd0, 32'hFFFFFFFF, 32'd1, 32'd0,        1'b1, 1'b0},
            '{3'd1, 32'd5,        32'd5, 32'd0,        1'b1, 1'b0}
        };
        run_table("addsub", v);
    endtask

    task automatic test_logic();
        vec_t v[] = '{
            '{3'd2, 32'd5,       32'd1,       32'd1,        1'b0, 1'b0},
            '{3'd3, 32'd4,       32'd1,       32'd5,        1'b0, 1'b0},
            '{3'd6, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0},
            '{3'd7, 32'd0,       32'd0,       32'hFFFFFFFF, 1'b0, 1'b1},
            '{3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0,      1'b1, 1'b0}
        };
        run_table("logic", v);
    endtask

    task automatic test_ult();
        vec_t v[] = '{
            '{3'd4, 32'd4,        32'd5,        32'd1, 1'b0, 1'b0},
            '{3'd4, 32'd5,        32'd4,        32'd0, 1'b1, 1'b0},
            '{3'd4, 32'hFFFFFFFF, 32'd0,        32'd0, 1'b1, 1'b0},
            '{3'd4, 32'd0,        32'hFFFFFFFF, 32'd1, 1'b0, 1'b0}
        };
        run_table("sltu", v);
    endtask

    task automatic test_slt();
        vec_t v[] = '{
            '{3'd5, 32'd4,        32'd5,        32'd1, 1'b0, 1'b0},
            '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 1'b1, 1'b0},
            '{3'd5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0},
            '{3'd5, 32'hFFFFFFFF, 32'd0,        32'd1, 1'b0, 1'b0},
            '{3'd5, 32'd0,        32'hFFFFFFFE, 32'd0, 1'b1, 1'b0},
            '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0},
            '{3'd5, 32'd0,        32'd2,        32'd1, 1'b0, 1'b0},
            '{3'd5, 32'd1,        32'd0,        32'd0, 1'b1, 1'b0},
            '{3'd5, 32'd9,        32'd5,        32'd0, 1'b1, 1'b0},
            '{3'd5, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0},
            '{3'd5, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1, 1'b0}
        };
        run_table("slt", v);
    endtask

    task automatic test_hold();
        apply(1'b0, 3'd6, 32'h12345678, 32'h0000FFFF);
        rega = 32'h0;
        regb = 32'h0;
        ALUopcode = 3'd7;
        #2;
        n_vec++;
        if ({result, zero, sign} !== {32'h1234A987, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_between_edges: got r=%h z=%b s=%b, want r=1234a987 z=0 s=0", result, zero, sign);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b, er;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            a  = $urandom;
            b  = $urandom;
            if (i == 5) b = a ^ 32'h80000000;
            er = ref_alu(op, a, b);
            apply(1'b0, op, a, b);
            n_vec++;
            if ({result, zero, sign} !== {er, (er == 32'd0), er[31]}) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] op=%0d a=%h b=%h: got r=%h z=%b s=%b, want r=%h z=%b s=%b",
                         i, op, a, b, result, zero, sign, er, (er == 32'd0), er[31]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        ALUopcode = 3'd0;
        rega = 32'd0;
        regb = 32'd0;
        test_reset();
        test_addsub();
        test_logic();
        test_ult();
        test_slt();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
